// File: rtl/dice_tid_dispatcher.sv
// Streams a wrapping TID range into the RF read ports and replays each TID on the write ports after the CGRA latency.
// Optional stall performance counter is built only when DICE_TID_DISPATCH_PERF_EN is defined.
module dice_tid_dispatcher #(
  parameter int unsigned NUM_PORTS        = 16,
  parameter int unsigned NUM_TID          = 512,
  parameter int unsigned RF_ADDR_WIDTH    = $clog2(NUM_TID),
  parameter int unsigned MAX_CGRA_LATENCY = 32,
  parameter int unsigned LW               = $clog2(MAX_CGRA_LATENCY + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_start,
  input  logic [RF_ADDR_WIDTH-1:0]           i_tid_base,
  input  logic [RF_ADDR_WIDTH:0]             i_tid_count,
  input  logic [LW-1:0]                      i_cgra_latency,
  input  logic [NUM_PORTS-1:0]               i_rd_port_mask,
  input  logic [NUM_PORTS-1:0]               i_wr_port_mask,
  input  logic                               i_stall,
  output logic [NUM_PORTS-1:0]               o_rd_en,
  output logic [NUM_PORTS*RF_ADDR_WIDTH-1:0] o_rd_tid,
  output logic [NUM_PORTS-1:0]               o_wr_en,
  output logic [NUM_PORTS*RF_ADDR_WIDTH-1:0] o_wr_tid,
  output logic                               o_busy,
  output logic                               o_done,
  output logic [31:0]                        o_perf_stall_cycles
);

  localparam int unsigned AW = RF_ADDR_WIDTH;
  localparam int unsigned CW = RF_ADDR_WIDTH + 1;
  localparam int unsigned IW = (MAX_CGRA_LATENCY > 1) ? $clog2(MAX_CGRA_LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [CW-1:0]                  r_cnt;
  logic [LW-1:0]                  r_lat;
  logic [NUM_PORTS-1:0]           r_rd_mask;
  logic [NUM_PORTS-1:0]           r_wr_mask;
  logic [CW-1:0]                  r_issued;
  logic [AW-1:0]                  r_next_tid;
  logic [CW-1:0]                  r_inflight;
  logic [MAX_CGRA_LATENCY-1:0]    r_dl_vld;
  logic [AW-1:0]                  r_dl_tid [MAX_CGRA_LATENCY];
  logic [NUM_PORTS-1:0]           r_rd_en;
  logic [NUM_PORTS*AW-1:0]        r_rd_tid;
  logic [NUM_PORTS-1:0]           r_wr_en;
  logic [NUM_PORTS*AW-1:0]        r_wr_tid;
  logic                           r_busy;
  logic                           r_done;

  logic [CW-1:0]                  w_cnt_clamp;
  logic [LW-1:0]                  w_lat_clamp;
  logic                           w_accept;
  logic                           w_issue;
  logic [AW-1:0]                  w_issue_tid;
  logic [LW-1:0]                  w_issue_lat;
  logic [IW-1:0]                  w_ins_idx;
  logic [CW-1:0]                  w_cnt_eff;
  logic [CW-1:0]                  w_issued_nxt;
  logic                           w_last;
  logic [AW-1:0]                  w_tid_inc;
  logic [NUM_PORTS-1:0]           w_rd_mask;
  logic [CW-1:0]                  w_inflight_nxt;

  // Launch config: live inputs on the accepting edge, latched copies afterwards
  assign w_cnt_clamp    = (i_tid_count > CW'(NUM_TID)) ? CW'(NUM_TID) : i_tid_count;
  assign w_lat_clamp    = (i_cgra_latency == '0) ? LW'(1) :
                          (i_cgra_latency > LW'(MAX_CGRA_LATENCY)) ? LW'(MAX_CGRA_LATENCY) :
                          i_cgra_latency;
  assign w_accept       = (r_state == S_IDLE) && i_start;
  assign w_issue        = !i_stall && ((w_accept && (w_cnt_clamp != '0)) || (r_state == S_ISSUE));
  assign w_issue_tid    = w_accept ? i_tid_base : r_next_tid;
  assign w_issue_lat    = w_accept ? w_lat_clamp : r_lat;
  assign w_ins_idx      = IW'(w_issue_lat - LW'(1));
  assign w_cnt_eff      = w_accept ? w_cnt_clamp : r_cnt;
  assign w_rd_mask      = w_accept ? i_rd_port_mask : r_rd_mask;
  assign w_issued_nxt   = (w_accept ? CW'(0) : r_issued) + CW'(w_issue);
  assign w_last         = w_issue && (w_issued_nxt == w_cnt_eff);
  assign w_tid_inc      = (w_issue_tid == AW'(NUM_TID - 1)) ? AW'(0) : w_issue_tid + AW'(1);
  assign w_inflight_nxt = r_inflight + CW'(w_issue) - CW'(r_dl_vld[0]);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_cnt_clamp == '0)  w_state_nxt = S_DONE;
          else if (w_last)        w_state_nxt = S_DRAIN;
          else                    w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: if (w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_inflight == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, launch registers, delay line and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_lat      <= '0;
      r_rd_mask  <= '0;
      r_wr_mask  <= '0;
      r_issued   <= '0;
      r_next_tid <= '0;
      r_inflight <= '0;
      r_dl_vld   <= '0;
      for (int j = 0; j < int'(MAX_CGRA_LATENCY); j++) r_dl_tid[j] <= '0;
      r_rd_en    <= '0;
      r_rd_tid   <= '0;
      r_wr_en    <= '0;
      r_wr_tid   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt     <= w_cnt_clamp;
        r_lat     <= w_lat_clamp;
        r_rd_mask <= i_rd_port_mask;
        r_wr_mask <= i_wr_port_mask;
      end
      if (w_accept || (r_state == S_ISSUE)) r_issued <= w_issued_nxt;
      if (w_issue)       r_next_tid <= w_tid_inc;
      else if (w_accept) r_next_tid <= i_tid_base;
      r_inflight <= w_inflight_nxt;

      // Shift toward slot 0 every cycle; a new TID enters at slot L-1
      for (int j = 0; j < int'(MAX_CGRA_LATENCY) - 1; j++) begin
        r_dl_vld[j] <= r_dl_vld[j+1];
        r_dl_tid[j] <= r_dl_tid[j+1];
      end
      r_dl_vld[MAX_CGRA_LATENCY-1] <= 1'b0;
      if (w_issue) begin
        r_dl_vld[w_ins_idx] <= 1'b1;
        r_dl_tid[w_ins_idx] <= w_issue_tid;
      end

      r_rd_en <= w_issue ? w_rd_mask : '0;
      if (w_issue) r_rd_tid <= {NUM_PORTS{w_issue_tid}};
      r_wr_en <= r_dl_vld[0] ? r_wr_mask : '0;
      if (r_dl_vld[0]) r_wr_tid <= {NUM_PORTS{r_dl_tid[0]}};
      r_busy <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_DRAIN);
      r_done <= (w_state_nxt == S_DONE);
    end
  end

  assign o_rd_en  = r_rd_en;
  assign o_rd_tid = r_rd_tid;
  assign o_wr_en  = r_wr_en;
  assign o_wr_tid = r_wr_tid;
  assign o_busy   = r_busy;
  assign o_done   = r_done;

`ifdef DICE_TID_DISPATCH_PERF_EN
  logic [31:0] r_perf_stall;

  // Saturating count of stalled ISSUE cycles, cleared on each accepted launch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
    end else if (w_accept) begin
      r_perf_stall <= '0;
    end else if ((r_state == S_ISSUE) && i_stall && (r_perf_stall != '1)) begin
      r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign o_perf_stall_cycles = r_perf_stall;
`else
  assign o_perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_dice_tid_dispatcher.sv
// Directed self-checking bench for dice_tid_dispatcher; cycle 0 is the cycle in which start is driven.
module tb_dice_tid_dispatcher;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [8:0]   tid_base;
  logic [9:0]   tid_count;
  logic [5:0]   cgra_latency;
  logic [15:0]  rd_mask;
  logic [15:0]  wr_mask;
  logic         stall;
  logic [15:0]  rd_en;
  logic [143:0] rd_tid;
  logic [15:0]  wr_en;
  logic [143:0] wr_tid;
  logic         busy;
  logic         done;
  logic [31:0]  perf;

  int n_cmp = 0;
  int n_err = 0;

  dice_tid_dispatcher dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_start             (start),
    .i_tid_base          (tid_base),
    .i_tid_count         (tid_count),
    .i_cgra_latency      (cgra_latency),
    .i_rd_port_mask      (rd_mask),
    .i_wr_port_mask      (wr_mask),
    .i_stall             (stall),
    .o_rd_en             (rd_en),
    .o_rd_tid            (rd_tid),
    .o_wr_en             (wr_en),
    .o_wr_tid            (wr_tid),
    .o_busy              (busy),
    .o_done              (done),
    .o_perf_stall_cycles (perf)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    tid_base = '0; tid_count = '0; cgra_latency = '0; rd_mask = '0; wr_mask = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (rd_en !== 16'h0)   begin n_err++; $display("FAIL reset rd_en got %h exp 0", rd_en); end
    n_cmp++; if (rd_tid !== '0)     begin n_err++; $display("FAIL reset rd_tid got %h exp 0", rd_tid); end
    n_cmp++; if (wr_en !== 16'h0)   begin n_err++; $display("FAIL reset wr_en got %h exp 0", wr_en); end
    n_cmp++; if (wr_tid !== '0)     begin n_err++; $display("FAIL reset wr_tid got %h exp 0", wr_tid); end
    n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset busy got %b exp 0", busy); end
    n_cmp++; if (done !== 1'b0)     begin n_err++; $display("FAIL reset done got %b exp 0", done); end
    n_cmp++; if (perf !== 32'd0)    begin n_err++; $display("FAIL reset perf got %0d exp 0", perf); end
    rst = 1'b0;
  endtask

  // base 0, N 4, L 3: reads cycles 1..4, writes 4..7, done 8
  task automatic test_basic();
    int xr[40]; int xw[40];
    logic [15:0] e_rd, e_wr; logic e_busy;
    for (int c = 0; c < 40; c++) begin xr[c] = -1; xw[c] = -1; end
    for (int i = 0; i < 4; i++) begin xr[1+i] = i; xw[4+i] = i; end
    @(negedge clk);
    tid_base = 9'd0; tid_count = 10'd4; cgra_latency = 6'd3;
    rd_mask = 16'hFFFF; wr_mask = 16'hFFFF; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      e_rd = (xr[c] < 0) ? 16'h0 : rd_mask;
      e_wr = (xw[c] < 0) ? 16'h0 : wr_mask;
      e_busy = (c >= 1) && (c < 8);
      n_cmp++; if (rd_en !== e_rd) begin n_err++; $display("FAIL basic rd_en c=%0d got %h exp %h", c, rd_en, e_rd); end
      n_cmp++; if (wr_en !== e_wr) begin n_err++; $display("FAIL basic wr_en c=%0d got %h exp %h", c, wr_en, e_wr); end
      if (xr[c] >= 0) begin n_cmp++; if (rd_tid !== {16{9'(xr[c])}}) begin n_err++; $display("FAIL basic rd_tid c=%0d got %0d exp %0d", c, rd_tid[8:0], xr[c]); end end
      if (xw[c] >= 0) begin n_cmp++; if (wr_tid !== {16{9'(xw[c])}}) begin n_err++; $display("FAIL basic wr_tid c=%0d got %0d exp %0d", c, wr_tid[8:0], xw[c]); end end
      n_cmp++; if (done !== (c == 8)) begin n_err++; $display("FAIL basic done c=%0d got %b exp %b", c, done, c == 8); end
      n_cmp++; if (busy !== e_busy)   begin n_err++; $display("FAIL basic busy c=%0d got %b exp %b", c, busy, e_busy); end
    end
  endtask

  // base 510, N 4, L 1, partial masks: TIDs wrap 510, 511, 0, 1
  task automatic test_wrap();
    int xr[40]; int xw[40];
    logic [15:0] e_rd, e_wr;
    int seq[4];
    seq[0] = 510; seq[1] = 511; seq[2] = 0; seq[3] = 1;
    for (int c = 0; c < 40; c++) begin xr[c] = -1; xw[c] = -1; end
    for (int i = 0; i < 4; i++) begin xr[1+i] = seq[i]; xw[2+i] = seq[i]; end
    @(negedge clk);
    tid_base = 9'd510; tid_count = 10'd4; cgra_latency = 6'd1;
    rd_mask = 16'h00F0; wr_mask = 16'h0F0F; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      e_rd = (xr[c] < 0) ? 16'h0 : 16'h00F0;
      e_wr = (xw[c] < 0) ? 16'h0 : 16'h0F0F;
      n_cmp++; if (rd_en !== e_rd) begin n_err++; $display("FAIL wrap rd_en c=%0d got %h exp %h", c, rd_en, e_rd); end
      n_cmp++; if (wr_en !== e_wr) begin n_err++; $display("FAIL wrap wr_en c=%0d got %h exp %h", c, wr_en, e_wr); end
      if (xr[c] >= 0) begin n_cmp++; if (rd_tid !== {16{9'(xr[c])}}) begin n_err++; $display("FAIL wrap rd_tid c=%0d got %0d exp %0d", c, rd_tid[8:0], xr[c]); end end
      if (xw[c] >= 0) begin n_cmp++; if (wr_tid !== {16{9'(xw[c])}}) begin n_err++; $display("FAIL wrap wr_tid c=%0d got %0d exp %0d", c, wr_tid[8:0], xw[c]); end end
      n_cmp++; if (done !== (c == 6)) begin n_err++; $display("FAIL wrap done c=%0d got %b exp %b", c, done, c == 6); end
    end
  endtask

  // N 6, L 2, stall sampled at the ends of cycles 2-3 blanks reads in cycles 3-4
  task automatic test_stall();
    int xr[40]; int xw[40];
    int rc[6];
    logic [15:0] e_rd, e_wr; logic e_busy;
    logic [31:0] e_perf;
    rc[0] = 1; rc[1] = 2; rc[2] = 5; rc[3] = 6; rc[4] = 7; rc[5] = 8;
    for (int c = 0; c < 40; c++) begin xr[c] = -1; xw[c] = -1; end
    for (int i = 0; i < 6; i++) begin xr[rc[i]] = 100 + i; xw[rc[i] + 2] = 100 + i; end
`ifdef DICE_TID_DISPATCH_PERF_EN
    e_perf = 32'd2;
`else
    e_perf = 32'd0;
`endif
    @(negedge clk);
    tid_base = 9'd100; tid_count = 10'd6; cgra_latency = 6'd2;
    rd_mask = 16'hFFFF; wr_mask = 16'hFFFF; start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      start = 1'b0;
      e_rd = (xr[c] < 0) ? 16'h0 : 16'hFFFF;
      e_wr = (xw[c] < 0) ? 16'h0 : 16'hFFFF;
      e_busy = (c >= 1) && (c < 11);
      n_cmp++; if (rd_en !== e_rd) begin n_err++; $display("FAIL stall rd_en c=%0d got %h exp %h", c, rd_en, e_rd); end
      n_cmp++; if (wr_en !== e_wr) begin n_err++; $display("FAIL stall wr_en c=%0d got %h exp %h", c, wr_en, e_wr); end
      if (xr[c] >= 0) begin n_cmp++; if (rd_tid !== {16{9'(xr[c])}}) begin n_err++; $display("FAIL stall rd_tid c=%0d got %0d exp %0d", c, rd_tid[8:0], xr[c]); end end
      if (xw[c] >= 0) begin n_cmp++; if (wr_tid !== {16{9'(xw[c])}}) begin n_err++; $display("FAIL stall wr_tid c=%0d got %0d exp %0d", c, wr_tid[8:0], xw[c]); end end
      n_cmp++; if (done !== (c == 11)) begin n_err++; $display("FAIL stall done c=%0d got %b exp %b", c, done, c == 11); end
      n_cmp++; if (busy !== e_busy)    begin n_err++; $display("FAIL stall busy c=%0d got %b exp %b", c, busy, e_busy); end
      stall = (c == 2) || (c == 3);
    end
    n_cmp++; if (perf !== e_perf) begin n_err++; $display("FAIL stall perf got %0d exp %0d", perf, e_perf); end
  endtask

  // start while busy and in DONE is ignored; start the cycle after DONE is taken
  task automatic test_start_ignored();
    int xr[40]; int xw[40];
    logic [15:0] e_rd, e_wr; logic e_busy, e_done;
    for (int c = 0; c < 40; c++) begin xr[c] = -1; xw[c] = -1; end
    for (int i = 0; i < 3; i++) begin xr[1+i] = 20 + i; xw[3+i] = 20 + i; end
    xr[8] = 40; xw[9] = 40;
    @(negedge clk);
    tid_base = 9'd20; tid_count = 10'd3; cgra_latency = 6'd2;
    rd_mask = 16'hFFFF; wr_mask = 16'hFFFF; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      e_rd = (xr[c] < 0) ? 16'h0 : 16'hFFFF;
      e_wr = (xw[c] < 0) ? 16'h0 : 16'hFFFF;
      e_busy = ((c >= 1) && (c <= 5)) || ((c >= 8) && (c <= 9));
      e_done = (c == 6) || (c == 10);
      n_cmp++; if (rd_en !== e_rd) begin n_err++; $display("FAIL ignore rd_en c=%0d got %h exp %h", c, rd_en, e_rd); end
      n_cmp++; if (wr_en !== e_wr) begin n_err++; $display("FAIL ignore wr_en c=%0d got %h exp %h", c, wr_en, e_wr); end
      if (xr[c] >= 0) begin n_cmp++; if (rd_tid !== {16{9'(xr[c])}}) begin n_err++; $display("FAIL ignore rd_tid c=%0d got %0d exp %0d", c, rd_tid[8:0], xr[c]); end end
      if (xw[c] >= 0) begin n_cmp++; if (wr_tid !== {16{9'(xw[c])}}) begin n_err++; $display("FAIL ignore wr_tid c=%0d got %0d exp %0d", c, wr_tid[8:0], xw[c]); end end
      n_cmp++; if (done !== e_done) begin n_err++; $display("FAIL ignore done c=%0d got %b exp %b", c, done, e_done); end
      n_cmp++; if (busy !== e_busy) begin n_err++; $display("FAIL ignore busy c=%0d got %b exp %b", c, busy, e_busy); end
      if (c == 2) begin tid_base = 9'd300; tid_count = 10'd5; cgra_latency = 6'd4; start = 1'b1; end
      if (c == 6) start = 1'b1;
      if (c == 7) begin tid_base = 9'd40; tid_count = 10'd1; cgra_latency = 6'd1; start = 1'b1; end
    end
  endtask

  // reset in DRAIN with two TIDs in flight: outputs clear, no write-back, next launch works
  task automatic test_reset_drain();
    int xr[40]; int xw[40];
    logic [15:0] e_rd, e_wr; logic e_busy;
    for (int c = 0; c < 40; c++) begin xr[c] = -1; xw[c] = -1; end
    xr[1] = 0; xr[2] = 1; xr[7] = 7; xw[8] = 7;
    @(negedge clk);
    tid_base = 9'd0; tid_count = 10'd2; cgra_latency = 6'd8;
    rd_mask = 16'hFFFF; wr_mask = 16'hFFFF; start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start = 1'b0;
      rst = 1'b0;
      e_rd = (xr[c] < 0) ? 16'h0 : 16'hFFFF;
      e_wr = (xw[c] < 0) ? 16'h0 : 16'hFFFF;
      e_busy = ((c >= 1) && (c <= 4)) || ((c >= 7) && (c <= 8));
      n_cmp++; if (rd_en !== e_rd) begin n_err++; $display("FAIL rstdrain rd_en c=%0d got %h exp %h", c, rd_en, e_rd); end
      n_cmp++; if (wr_en !== e_wr) begin n_err++; $display("FAIL rstdrain wr_en c=%0d got %h exp %h", c, wr_en, e_wr); end
      if (xr[c] >= 0) begin n_cmp++; if (rd_tid !== {16{9'(xr[c])}}) begin n_err++; $display("FAIL rstdrain rd_tid c=%0d got %0d exp %0d", c, rd_tid[8:0], xr[c]); end end
      if (xw[c] >= 0) begin n_cmp++; if (wr_tid !== {16{9'(xw[c])}}) begin n_err++; $display("FAIL rstdrain wr_tid c=%0d got %0d exp %0d", c, wr_tid[8:0], xw[c]); end end
      n_cmp++; if (done !== (c == 9)) begin n_err++; $display("FAIL rstdrain done c=%0d got %b exp %b", c, done, c == 9); end
      n_cmp++; if (busy !== e_busy)   begin n_err++; $display("FAIL rstdrain busy c=%0d got %b exp %b", c, busy, e_busy); end
      if (c == 5) begin
        n_cmp++; if ((rd_tid !== '0) || (wr_tid !== '0) || (perf !== 32'd0)) begin n_err++; $display("FAIL rstdrain tids_cleared got rd %0d wr %0d perf %0d exp 0", rd_tid[8:0], wr_tid[8:0], perf); end
      end
      if (c == 4) rst = 1'b1;
      if (c == 6) begin tid_base = 9'd7; tid_count = 10'd1; cgra_latency = 6'd1; start = 1'b1; end
    end
  endtask

  // tid_count 0: done in cycle 1 only, no enables, busy stays low
  task automatic test_zero_count();
    @(negedge clk);
    tid_base = 9'd33; tid_count = 10'd0; cgra_latency = 6'd3;
    rd_mask = 16'hFFFF; wr_mask = 16'hFFFF; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      n_cmp++; if (done !== (c == 1)) begin n_err++; $display("FAIL zero done c=%0d got %b exp %b", c, done, c == 1); end
      n_cmp++; if ((rd_en !== 16'h0) || (wr_en !== 16'h0) || (busy !== 1'b0)) begin n_err++; $display("FAIL zero quiet c=%0d got rd %h wr %h busy %b exp 0", c, rd_en, wr_en, busy); end
    end
  endtask

  // tid_count 600 clamps to 512 issues, wrapping from base 5
  task automatic test_clamp_count();
    int n_rd = 0; int n_wr = 0; int tid_bad = 0; int done_c = -1;
    @(negedge clk);
    tid_base = 9'd5; tid_count = 10'd600; cgra_latency = 6'd1;
    rd_mask = 16'hFFFF; wr_mask = 16'hFFFF; start = 1'b1;
    for (int c = 1; c <= 520; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (rd_en != 16'h0) begin
        n_rd++;
        if (rd_tid[8:0] != 9'((5 + c - 1) % 512)) tid_bad++;
      end
      if (wr_en != 16'h0) n_wr++;
      if (done && (done_c < 0)) done_c = c;
    end
    n_cmp++; if (n_rd !== 512)   begin n_err++; $display("FAIL clamp rd_count got %0d exp 512", n_rd); end
    n_cmp++; if (n_wr !== 512)   begin n_err++; $display("FAIL clamp wr_count got %0d exp 512", n_wr); end
    n_cmp++; if (tid_bad !== 0)  begin n_err++; $display("FAIL clamp tid_seq got %0d bad exp 0", tid_bad); end
    n_cmp++; if (done_c !== 514) begin n_err++; $display("FAIL clamp done_cycle got %0d exp 514", done_c); end
  endtask

  // cgra_latency 0 behaves as 1; latency above MAX clamps to 32
  task automatic test_latency_clamp();
    int wr_c = -1; int done_c = -1;
    @(negedge clk);
    tid_base = 9'd3; tid_count = 10'd2; cgra_latency = 6'd0;
    rd_mask = 16'hFFFF; wr_mask = 16'hFFFF; start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      n_cmp++; if (wr_en !== (((c == 2) || (c == 3)) ? 16'hFFFF : 16'h0)) begin n_err++; $display("FAIL lat0 wr_en c=%0d got %h", c, wr_en); end
      if ((c == 2) || (c == 3)) begin n_cmp++; if (wr_tid[8:0] !== 9'(c + 1)) begin n_err++; $display("FAIL lat0 wr_tid c=%0d got %0d exp %0d", c, wr_tid[8:0], c + 1); end end
      n_cmp++; if (done !== (c == 4)) begin n_err++; $display("FAIL lat0 done c=%0d got %b exp %b", c, done, c == 4); end
    end
    @(negedge clk);
    tid_base = 9'd0; tid_count = 10'd1; cgra_latency = 6'd50; start = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      start = 1'b0;
      if ((wr_en != 16'h0) && (wr_c < 0)) wr_c = c;
      if (done && (done_c < 0)) done_c = c;
    end
    n_cmp++; if (wr_c !== 33)   begin n_err++; $display("FAIL latmax wr_cycle got %0d exp 33", wr_c); end
    n_cmp++; if (done_c !== 34) begin n_err++; $display("FAIL latmax done_cycle got %0d exp 34", done_c); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_start_ignored();
    test_reset_drain();
    test_zero_count();
    test_clamp_count();
    test_latency_clamp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
